// File: rtl/spi_req_arbiter.sv
// ==== spi_req_arbiter : round-robin sharer of one SPI shift engine among NUM_REQ requesters ====
// ==== optional WAIT timeout under SPI_ARB_TIMEOUT_EN                          rev 1.0 ====
`default_nettype none

module spi_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_wdata,
    output logic [IW-1:0]             spi_sel,
    input  logic                      spi_done,
    input  logic [DATA_W-1:0]         spi_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic [IW:0]        cand;
    logic               timeout_hit;

    // Search begins at the priority pointer and wraps; first requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_vld && req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_vld) state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (spi_done || timeout_hit) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        ack_d   = '0;
        if (state_q == S_IDLE && win_vld) begin
            idx_d = win_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_idx == IW'(i)) wdata_d = req_data[i*DATA_W +: DATA_W];
            end
        end
        if (state_q == S_WAIT) begin
            if (spi_done)         rd_d = spi_rdata;
            else if (timeout_hit) rd_d = '1;
        end
        if (state_q == S_RELEASE) begin
            ptr_d = (idx_q == IW'(NUM_REQ-1)) ? '0 : idx_q + IW'(1);
        end
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        if (state_d != S_IDLE)    gnt_d[idx_d] = 1'b1;
        if (state_d == S_RELEASE) ack_d[idx_d] = 1'b1;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;

    assign timeout_hit = (state_q == S_WAIT) && (to_cnt_q == CW'(TIMEOUT_CYC - 1));
    assign to_cnt_d    = (state_q == S_WAIT) ? to_cnt_q + CW'(1) : '0;
    // A done arriving on the limit cycle wins over the timeout.
    assign to_err_d    = timeout_hit && !spi_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
    if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_ignored
    end
`endif

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign spi_start = start_q;
    assign spi_wdata = wdata_q;
    assign spi_sel   = idx_q;

endmodule

`default_nettype wire
